// File: rtl/order_book_engine_pkg.sv
// Shared constants and types for the order book engine.
//   - field widths (price Q8.8, order id, quantity, stock select)
//   - request opcodes, book_entry layout, FSM state encoding
//   - saturating quantity subtraction helper
package order_book_engine_pkg;

  localparam int PRICE_INDEX     = 15;
  localparam int ORDER_INDEX     = 7;
  localparam int QUANTITY_INDEX  = 7;
  localparam int STOCK_INDEX     = 1;
  localparam int NUM_STOCK_INDEX = 3;

  localparam int DEPTH      = 8;
  localparam int NUM_STOCKS = NUM_STOCK_INDEX + 1;
  localparam int SLOT_W     = $clog2(DEPTH);

  // DEPTH expressed in the width of the per-book counter
  localparam logic [3:0] DEPTH_CNT = 4'(DEPTH);

  localparam logic [2:0] ADD_ORDER    = 3'd1;
  localparam logic [2:0] CANCEL_ORDER = 3'd2;
  localparam logic [2:0] TRADE_ORDER  = 3'd3;

  typedef struct packed {
    logic [PRICE_INDEX:0]    price;
    logic [ORDER_INDEX:0]    order_id;
    logic [QUANTITY_INDEX:0] quantity;
  } book_entry;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SCAN  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Quantity reduction that never wraps below zero
  function automatic logic [QUANTITY_INDEX:0] sat_sub(
    input logic [QUANTITY_INDEX:0] a,
    input logic [QUANTITY_INDEX:0] b
  );
    if (a > b) begin
      sat_sub = a - b;
    end else begin
      sat_sub = '0;
    end
  endfunction

endpackage

// File: rtl/order_book_engine.sv
// Bounded limit-order books (one per stock) with a serialising FSM.
// Each start pulse in IDLE applies one ADD / CANCEL / TRADE operation to the
// selected book; entries stay sorted by price descending, FIFO among equals.
// Ports:
//   clk_in, rst_in      clock, async active-low reset
//   stock_to_add        book selected for the operation
//   order_to_add        entry inserted by ADD_ORDER
//   start, request      request strobe and opcode
//   order_id            target of CANCEL/TRADE
//   delete, quantity    whole-order cancel flag, reduce/trade amount
//   is_busy             high while an operation is in progress
//   best_price          head price of last-operated book (0 if empty)
//   book_count          entries in last-operated book
//   op_error            last operation failed (book full / id not found)
module order_book_engine
  import order_book_engine_pkg::*;
(
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [STOCK_INDEX:0]    stock_to_add,
  input  book_entry               order_to_add,
  input  logic                    start,
  input  logic [2:0]              request,
  input  logic [ORDER_INDEX:0]    order_id,
  input  logic                    delete,
  input  logic [QUANTITY_INDEX:0] quantity,
  output logic                    is_busy,
  output logic [PRICE_INDEX:0]    best_price,
  output logic [3:0]              book_count,
  output logic                    op_error
);

  state_e                  state_q;
  book_entry               book_q  [NUM_STOCKS][DEPTH];
  logic [3:0]              count_q [NUM_STOCKS];

  // Operation fields latched at the accepting edge
  logic [STOCK_INDEX:0]    stock_q;
  book_entry               entry_q;
  logic [2:0]              req_q;
  logic [ORDER_INDEX:0]    oid_q;
  logic                    del_q;
  logic [QUANTITY_INDEX:0] qty_q;

  // idx_q walks the book during SCAN/SHIFT; pos_q is the insert slot
  logic [3:0]              idx_q;
  logic [SLOT_W-1:0]       pos_q;
  logic                    err_q;

  logic                    busy_q;
  logic [PRICE_INDEX:0]    best_price_q;
  logic [3:0]              book_count_q;
  logic                    op_error_q;

  logic [3:0]              cnt_s;
  logic [3:0]              last_s;
  logic [SLOT_W-1:0]       slot_s;
  logic [SLOT_W-1:0]       next_slot_s;
  book_entry               cur_s;
  book_entry               next_s;
  logic                    at_end_s;
  logic                    id_hit_s;
  logic                    remove_s;

  // Views of the latched book at the current walk position
  always_comb begin
    cnt_s       = count_q[stock_q];
    last_s      = cnt_s - 4'd1;
    slot_s      = idx_q[SLOT_W-1:0];
    next_slot_s = slot_s + 3'd1;
    cur_s       = book_q[stock_q][slot_s];
    next_s      = book_q[stock_q][next_slot_s];
    at_end_s    = (idx_q == cnt_s);
    id_hit_s    = (cur_s.order_id == oid_q);
    // TRADE ignores delete; any reduction reaching zero removes the entry
    remove_s    = ((req_q == CANCEL_ORDER) && del_q) || (qty_q >= cur_s.quantity);
  end

  // Operation FSM, book storage and registered outputs
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q      <= ST_IDLE;
      for (int s = 0; s < NUM_STOCKS; s++) begin
        count_q[s] <= 4'd0;
        for (int i = 0; i < DEPTH; i++) begin
          book_q[s][i] <= '0;
        end
      end
      stock_q      <= '0;
      entry_q      <= '0;
      req_q        <= 3'd0;
      oid_q        <= '0;
      del_q        <= 1'b0;
      qty_q        <= '0;
      idx_q        <= 4'd0;
      pos_q        <= '0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      best_price_q <= '0;
      book_count_q <= 4'd0;
      op_error_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            stock_q <= stock_to_add;
            entry_q <= order_to_add;
            req_q   <= request;
            oid_q   <= order_id;
            del_q   <= delete;
            qty_q   <= quantity;
            idx_q   <= 4'd0;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            case (request)
              ADD_ORDER: begin
                if (count_q[stock_to_add] == DEPTH_CNT) begin
                  err_q   <= 1'b1;
                  state_q <= ST_DONE;
                end else begin
                  state_q <= ST_SCAN;
                end
              end
              CANCEL_ORDER, TRADE_ORDER: state_q <= ST_SCAN;
              default:                   state_q <= ST_DONE;
            endcase
          end
        end

        ST_SCAN: begin
          if (req_q == ADD_ORDER) begin
            if (at_end_s) begin
              pos_q   <= slot_s;
              state_q <= ST_WRITE;
            end else if (cur_s.price < entry_q.price) begin
              // Make room: shift from the tail back to the insert slot
              pos_q   <= slot_s;
              idx_q   <= last_s;
              state_q <= ST_SHIFT;
            end else begin
              idx_q   <= idx_q + 4'd1;
            end
          end else begin
            if (at_end_s) begin
              err_q   <= 1'b1;
              state_q <= ST_DONE;
            end else if (id_hit_s) begin
              if (remove_s) begin
                state_q <= ST_SHIFT;
              end else begin
                book_q[stock_q][slot_s].quantity <= sat_sub(cur_s.quantity, qty_q);
                state_q <= ST_DONE;
              end
            end else begin
              idx_q   <= idx_q + 4'd1;
            end
          end
        end

        ST_SHIFT: begin
          if (req_q == ADD_ORDER) begin
            book_q[stock_q][next_slot_s] <= cur_s;
            if (slot_s == pos_q) begin
              state_q <= ST_WRITE;
            end else begin
              idx_q   <= idx_q - 4'd1;
            end
          end else begin
            if (idx_q == last_s) begin
              book_q[stock_q][slot_s] <= '0;
              count_q[stock_q]        <= last_s;
              state_q                 <= ST_DONE;
            end else begin
              book_q[stock_q][slot_s] <= next_s;
              idx_q                   <= idx_q + 4'd1;
            end
          end
        end

        ST_WRITE: begin
          book_q[stock_q][pos_q] <= entry_q;
          count_q[stock_q]       <= cnt_s + 4'd1;
          state_q                <= ST_DONE;
        end

        ST_DONE: begin
          best_price_q <= (cnt_s == 4'd0) ? '0 : book_q[stock_q][0].price;
          book_count_q <= cnt_s;
          op_error_q   <= err_q;
          busy_q       <= 1'b0;
          state_q      <= ST_IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign is_busy    = busy_q;
  assign best_price = best_price_q;
  assign book_count = book_count_q;
  assign op_error   = op_error_q;

endmodule

// File: tb/tb_order_book_engine.sv
// Self-checking bench for order_book_engine: directed scenarios followed by
// random operations, compared against a queue-based book model.
module tb_order_book_engine;
  import order_book_engine_pkg::*;

  logic                    clk_in = 1'b0;
  logic                    rst_in;
  logic [STOCK_INDEX:0]    stock_to_add;
  book_entry               order_to_add;
  logic                    start;
  logic [2:0]              request;
  logic [ORDER_INDEX:0]    order_id;
  logic                    del_in;
  logic [QUANTITY_INDEX:0] quantity;
  logic                    is_busy;
  logic [PRICE_INDEX:0]    best_price;
  logic [3:0]              book_count;
  logic                    op_error;

  int checks = 0;
  int errors = 0;
  int last_cycles;

  // Reference books: index 0 is the best entry
  book_entry model_q [NUM_STOCKS][$];

  order_book_engine dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .stock_to_add (stock_to_add),
    .order_to_add (order_to_add),
    .start        (start),
    .request      (request),
    .order_id     (order_id),
    .delete       (del_in),
    .quantity     (quantity),
    .is_busy      (is_busy),
    .best_price   (best_price),
    .book_count   (book_count),
    .op_error     (op_error)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic book_entry mk(input logic [15:0] p, input logic [7:0] id, input logic [7:0] q);
    book_entry e;
    e.price    = p;
    e.order_id = id;
    e.quantity = q;
    return e;
  endfunction

  function automatic void model_apply(input int s, input logic [2:0] req, input book_entry e,
                                      input logic [7:0] oid, input logic del, input logic [7:0] qty,
                                      output logic err);
    int        pos;
    int        k;
    book_entry t;
    err = 1'b0;
    if (req == ADD_ORDER) begin
      if (model_q[s].size() >= DEPTH) begin
        err = 1'b1;
      end else begin
        pos = model_q[s].size();
        for (int i = model_q[s].size() - 1; i >= 0; i--) begin
          if (model_q[s][i].price < e.price) pos = i;
        end
        model_q[s].insert(pos, e);
      end
    end else if (req == CANCEL_ORDER || req == TRADE_ORDER) begin
      k = -1;
      for (int i = model_q[s].size() - 1; i >= 0; i--) begin
        if (model_q[s][i].order_id == oid) k = i;
      end
      if (k < 0) begin
        err = 1'b1;
      end else begin
        t = model_q[s][k];
        if ((req == CANCEL_ORDER && del) || qty >= t.quantity) begin
          model_q[s].delete(k);
        end else begin
          t.quantity = t.quantity - qty;
          model_q[s][k] = t;
        end
      end
    end
  endfunction

  task automatic do_op(input int s, input logic [2:0] req, input book_entry e, input logic [7:0] oid,
                       input logic del, input logic [7:0] qty, input bit poke, input string tag);
    int   cyc;
    logic exp_err;
    logic [15:0] exp_best;
    @(negedge clk_in);
    stock_to_add = 2'(s);
    request      = req;
    order_to_add = e;
    order_id     = oid;
    del_in       = del;
    quantity     = qty;
    start        = 1'b1;
    @(negedge clk_in);
    start = 1'b0;
    cyc = 0;
    while (is_busy === 1'b1 && cyc < 40) begin
      cyc++;
      if (poke && cyc == 1) begin
        // Request arriving while busy must be ignored
        stock_to_add = 2'(s + 1);
        request      = ADD_ORDER;
        order_to_add = mk(16'h5555, 8'hEE, 8'd1);
        start        = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk_in);
    end
    start = 1'b0;
    last_cycles = cyc;
    chk({tag, "_latency"}, 32'((cyc >= 1) && (cyc <= 2 * DEPTH + 3)), 32'd1);
    model_apply(s, req, e, oid, del, qty, exp_err);
    exp_best = (model_q[s].size() == 0) ? 16'h0 : model_q[s][0].price;
    chk({tag, "_best"},  32'(best_price), 32'(exp_best));
    chk({tag, "_count"}, 32'(book_count), 32'(model_q[s].size()));
    chk({tag, "_err"},   32'(op_error),   32'(exp_err));
  endtask

  task automatic probe(input int s);
    do_op(s, 3'd0, '0, 8'd0, 1'b0, 8'd0, 1'b0, "probe");
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"},  32'(is_busy),    32'd0);
    chk({tag, "_best"},  32'(best_price), 32'd0);
    chk({tag, "_count"}, 32'(book_count), 32'd0);
    chk({tag, "_err"},   32'(op_error),   32'd0);
  endtask

  initial begin
    rst_in       = 1'b0;
    start        = 1'b0;
    stock_to_add = '0;
    order_to_add = '0;
    request      = 3'd0;
    order_id     = '0;
    del_in       = 1'b0;
    quantity     = '0;

    // Power-on reset for two cycles
    repeat (2) @(negedge clk_in);
    check_reset_outputs("reset");
    rst_in = 1'b1;

    // First add into an empty book: busy exactly 3 cycles
    do_op(0, ADD_ORDER, mk(16'h7300, 8'd1, 8'd1), 8'd0, 1'b0, 8'd0, 1'b0, "add_empty");
    chk("add_empty_cycles", 32'(last_cycles), 32'd3);
    chk("add_empty_price",  32'(best_price),  32'h7300);

    // Seed the other books, then replace id 1 with new prices on each stock
    for (int s = 1; s < NUM_STOCKS; s++)
      do_op(s, ADD_ORDER, mk(16'(16'h4000 + s * 16'h100), 8'd1, 8'd1), 8'd0, 1'b0, 8'd0, 1'b0, "seed");
    do_op(0, CANCEL_ORDER, '0, 8'd1, 1'b1, 8'd0, 1'b0, "upd_cancel");
    do_op(0, ADD_ORDER, mk(16'h7F00, 8'd1, 8'd1), 8'd0, 1'b0, 8'd0, 1'b0, "upd_add");
    chk("upd_price", 32'(best_price), 32'h7F00);
    for (int r = 0; r < 3; r++) begin
      for (int s = 0; s < NUM_STOCKS; s++) begin
        do_op(s, CANCEL_ORDER, '0, 8'd1, 1'b1, 8'd0, 1'b0, "upd_cancel");
        do_op(s, ADD_ORDER, mk(16'($urandom_range(16'h0100, 16'hFF00)), 8'd1, 8'd1),
              8'd0, 1'b0, 8'd0, 1'b0, "upd_add");
        for (int p = 0; p < NUM_STOCKS; p++) probe(p);
      end
    end

    // Reset in the middle of an ADD clears everything
    @(negedge clk_in);
    stock_to_add = 2'd0;
    request      = ADD_ORDER;
    order_to_add = mk(16'h1111, 8'd9, 8'd1);
    start        = 1'b1;
    @(negedge clk_in);
    start  = 1'b0;
    rst_in = 1'b0;
    #1;
    check_reset_outputs("midop_reset");
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
    for (int s = 0; s < NUM_STOCKS; s++) model_q[s].delete();
    for (int s = 0; s < NUM_STOCKS; s++) probe(s);

    // Sort order with an equal-price FIFO tie
    do_op(2, ADD_ORDER, mk(16'h2000, 8'd1, 8'd1), 8'd0, 1'b0, 8'd0, 1'b0, "ord");
    do_op(2, ADD_ORDER, mk(16'h3000, 8'd2, 8'd1), 8'd0, 1'b0, 8'd0, 1'b0, "ord");
    do_op(2, ADD_ORDER, mk(16'h3000, 8'd3, 8'd1), 8'd0, 1'b0, 8'd0, 1'b0, "ord");
    do_op(2, ADD_ORDER, mk(16'h1000, 8'd4, 8'd1), 8'd0, 1'b0, 8'd0, 1'b0, "ord");
    chk("ord_best",  32'(best_price), 32'h3000);
    chk("ord_count", 32'(book_count), 32'd4);
    do_op(2, CANCEL_ORDER, '0, 8'd2, 1'b1, 8'd0, 1'b0, "ord_rm2");
    chk("ord_rm2_best", 32'(best_price), 32'h3000);
    do_op(2, CANCEL_ORDER, '0, 8'd3, 1'b1, 8'd0, 1'b0, "ord_rm3");
    chk("ord_rm3_best", 32'(best_price), 32'h2000);

    // Full book rejects an add; unknown id is an error
    for (int i = 0; i < DEPTH; i++)
      do_op(1, ADD_ORDER, mk(16'($urandom_range(1, 8) * 256), 8'(10 + i), 8'd2),
            8'd0, 1'b0, 8'd0, 1'b0, "fill");
    do_op(1, ADD_ORDER, mk(16'hFFFF, 8'd50, 8'd1), 8'd0, 1'b0, 8'd0, 1'b0, "full");
    chk("full_err",   32'(op_error),   32'd1);
    chk("full_count", 32'(book_count), 32'd8);
    do_op(1, CANCEL_ORDER, '0, 8'd99, 1'b1, 8'd0, 1'b0, "missing");
    chk("missing_err", 32'(op_error), 32'd1);

    // Trades reduce then remove; a start pulse while busy is ignored
    do_op(3, ADD_ORDER, mk(16'h1234, 8'd1, 8'd3), 8'd0, 1'b0, 8'd0, 1'b0, "trd_add");
    do_op(3, TRADE_ORDER, '0, 8'd1, 1'b1, 8'd1, 1'b1, "trd1");
    chk("trd1_count", 32'(book_count), 32'd1);
    do_op(3, TRADE_ORDER, '0, 8'd1, 1'b0, 8'd1, 1'b0, "trd2");
    chk("trd2_count", 32'(book_count), 32'd1);
    do_op(3, TRADE_ORDER, '0, 8'd1, 1'b0, 8'd5, 1'b0, "trd3");
    chk("trd3_count", 32'(book_count), 32'd0);
    probe(0);
    chk("poke_count", 32'(book_count), 32'd0);

    // Random operations against the model
    for (int n = 0; n < 300; n++) begin
      int          s;
      logic [2:0]  rq;
      s  = $urandom_range(0, NUM_STOCKS - 1);
      rq = 3'($urandom_range(0, 4));
      if ($urandom_range(0, 2) == 0) rq = ADD_ORDER;
      do_op(s, rq, mk(16'($urandom_range(1, 6) * 16'h1000 + $urandom_range(0, 1) * 16'h80),
                      8'($urandom_range(0, 7)), 8'($urandom_range(0, 5))),
            8'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 4)),
            ($urandom_range(0, 7) == 0), "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
